// File: rtl/axi_info_pkg.sv
// Shared types for the info-block reader.
//   resp_t  : AXI read response code, with the two codes the reader cares about
//   state_e : reader sequencing states
//   idx_width(): width of an index into n entries, never less than one bit
package axi_info_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_info_reader_fifo.sv
// Small synchronous FIFO holding read replies (data + tlast) until the
// stream side takes them. Any DEPTH >= 1 works; pointers wrap explicitly.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i   : write one entry (ignored when full unless popping)
//   pop_i           : remove the head entry (ignored when empty)
//   dout_o          : head entry, valid while !empty_o
//   full_o, empty_o : occupancy flags
//   count_o         : number of entries held
module axi_info_reader_fifo
    import axi_info_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 33,
    localparam int PW    = idx_width(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/axi_info_reader.sv
// AXI-lite read master that dumps word addresses 0..N-1 of the info block
// and forwards the replies, in order, as one AXI-stream packet (tlast on the
// final word).
//   ap_clk, ap_rst_n        : clock, asynchronous active-low reset
//   start / busy / done     : request, activity flag, completion pulse
//   m_axi_AR*               : read address channel (ARADDR is a word index)
//   m_axi_R*                : read data channel
//   m_axis_*                : output stream
//   err                     : sticky bad-response flag
// Build option: define AXI_INFO_READER_ERR_EN to add the err port; otherwise
// RRESP is ignored.
module axi_info_reader
    import axi_info_pkg::*;
#(
    parameter int  N               = 9,
    parameter int  AXI_DATA_WIDTH  = 32,
    parameter int  MAX_OUTSTANDING = 2,
    localparam int AW              = idx_width(N)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      m_axi_ARVALID,
    input  logic                      m_axi_ARREADY,
    output logic [AW-1:0]             m_axi_ARADDR,
    input  logic                      m_axi_RVALID,
    output logic                      m_axi_RREADY,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic [1:0]                m_axi_RRESP,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast
`ifdef AXI_INFO_READER_ERR_EN
    ,
    output logic                      err
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = AXI_DATA_WIDTH + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [CW:0]   OUT_LIM  = MAX_OUTSTANDING[CW:0];

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] beat_q, beat_d;
    logic [CW-1:0] infl_q, infl_d;
    logic          done_q, done_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] fifo_dout;
    logic [CW:0]   used;
    logic          ar_hs, r_hs, pop, has_credit;

    assign pop   = m_axis_tvalid && m_axis_tready;
    assign ar_hs = m_axi_ARVALID && m_axi_ARREADY;
    assign r_hs  = m_axi_RVALID && m_axi_RREADY;

    // Slots claimed = reads in flight + words buffered. A word leaving the
    // buffer this cycle already frees its slot, which keeps issue at one
    // word per cycle. Once ARVALID rises its credit cannot vanish: pushes
    // only move a slot from in-flight to buffered, and a counted pop has
    // really happened by the next cycle.
    assign used       = {1'b0, infl_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    assign has_credit = (used < OUT_LIM) && !(fifo_full && !pop);

    assign m_axi_ARVALID = (state_q == ISSUE) && has_credit;
    assign m_axi_ARADDR  = addr_q;
    // Space is reserved at issue time, so R is never back-pressured.
    assign m_axi_RREADY  = (infl_q != '0);

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_dout[AXI_DATA_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && fifo_dout[AXI_DATA_WIDTH];

    assign busy = (state_q != IDLE);
    assign done = done_q;

    // tlast rides with the data, tagged from the reply count rather than
    // the address counter.
    axi_info_reader_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .push_i  (r_hs),
        .din_i   ({beat_q == LAST_IDX, m_axi_RDATA}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        infl_d  = infl_q + CW'(ar_hs) - CW'(r_hs);
        if (ar_hs) addr_d = addr_q + 1'b1;
        if (r_hs)  beat_d = beat_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                    beat_d  = '0;
                end
            end
            ISSUE: begin
                if (ar_hs && (addr_q == LAST_IDX)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            infl_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            infl_q  <= infl_d;
            done_q  <= done_d;
        end
    end

`ifdef AXI_INFO_READER_ERR_EN
    logic err_q, err_d;

    // A new packet clears the flag; bad beats are still forwarded.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && start)
            err_d = 1'b0;
        else if (r_hs && (m_axi_RRESP != RESP_OKAY))
            err_d = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi_RRESP;
`endif

endmodule

// File: doc/axi_info_reader.md
Name: axi_info_reader

Overview:
AXI-lite read master placed directly upstream of axi_info. On a start pulse it walks word addresses 0..N-1, collects the read replies and forwards them in order as an AXI-stream packet, asserting TLAST on the final word. Used on the card-side host path and by the self-check harness to dump the compiled-in info block without a CPU.

Parameters:
N, 9, number of info words to read; N >= 1.
AXI_DATA_WIDTH, 32, AXI-lite RDATA and stream TDATA width.
MAX_OUTSTANDING, 2, maximum reads in flight, equal to the output buffer depth; must be >= 1.

Ports:
ap_clk  in  1  clock.
ap_rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  single-cycle request to read the whole block.
busy  out  1  high from accepted start until the last beat handshakes.
done  out  1  one-cycle pulse in the cycle after the last beat handshakes.
m_axi_ARVALID  out  1  read address valid.
m_axi_ARREADY  in  1  read address ready.
m_axi_ARADDR  out  $clog2(N) (min 1)  word index, not a byte address.
m_axi_RVALID  in  1  read data valid.
m_axi_RREADY  out  1  read data ready.
m_axi_RDATA  in  AXI_DATA_WIDTH  read data.
m_axi_RRESP  in  2  read response.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
m_axis_tdata  out  AXI_DATA_WIDTH  info word.
m_axis_tlast  out  1  high on word N-1.
err  out  1  sticky error flag, present only with AXI_INFO_READER_ERR_EN.

Behaviour:
- Reset values: busy=0, done=0, ARVALID=0, ARADDR=0, RREADY=0, tvalid=0, tlast=0, err=0, FSM=IDLE, buffer empty.
- FSM IDLE -> ISSUE on start. ISSUE -> DRAIN once address N-1 has handshaken on AR. DRAIN -> IDLE when the last beat handshakes on the stream. done pulses in the following cycle.
- start is ignored outside IDLE.
- Credits: credits = MAX_OUTSTANDING - (reads in flight + buffer occupancy). ARVALID is asserted only while in ISSUE and credits > 0.
- AR handshake rules:
  - Once ARVALID is asserted, it and ARADDR stay stable until ARREADY.
  - ARADDR increments by one per handshake.
  - A new ARVALID may follow in the cycle after a handshake, giving back-to-back issue.
- RREADY is high whenever a read is in flight; space for the reply is already reserved, so R never stalls. Replies are assumed to arrive in order.
- R beat: RDATA is pushed into the buffer in the same cycle. A beat arriving with no read in flight is dropped.
- Stream output:
  - Head of buffer drives tdata/tvalid.
  - tdata/tlast stay stable while tvalid && !tready.
  - tlast is derived from a beat counter, not from ARADDR.
- Latency: with ARREADY, RVALID and tready held high, the first tvalid comes 2 cycles after start plus the slave latency. Sustained rate is 1 word/cycle when MAX_OUTSTANDING >= slave round trip.
- Boundaries:
  - N=1: single beat with tlast=1.
  - Full buffer: credits=0, so ARVALID stays deasserted.
  - Simultaneous push and pop on a full buffer is legal.
  - Reset mid-packet flushes the buffer and drops in-flight state. The slave must be reset together with this block.

Optional Feature:
AXI_INFO_READER_ERR_EN.
- Defined:
  - err port exists; it is set on any accepted R beat with RRESP != 2'b00.
  - err clears on the next accepted start or on reset; the data is still forwarded.
  - busy and done behave unchanged.
- Undefined: the err port is absent and RRESP is ignored.

Decomposition:
- Package axi_info_pkg: typedef resp_t (2-bit) with constants RESP_OKAY, RESP_SLVERR; typedef state_e {IDLE, ISSUE, DRAIN}.
- Sub-module axi_info_reader_fifo: synchronous FIFO with parameters DEPTH=MAX_OUTSTANDING and WIDTH=AXI_DATA_WIDTH+1 (tlast bit), ports push/pop/full/empty/count. This is where the credit computation gets its occupancy.

Test Plan:
- Default DATA (0x24379827 … 0x7f779af9), ARREADY=RVALID=tready=1: start -> 9 beats on consecutive cycles in order, tlast only on 0x7f779af9, done one cycle later, busy=0.
- Random ARREADY/tready (~40% low), MAX_OUTSTANDING=1 -> identical 9-word sequence, never more than 1 read outstanding, ARVALID/ARADDR stable while ARREADY=0.
- tready=0 for 20 cycles after start, MAX_OUTSTANDING=2 -> exactly 2 AR handshakes, then ARVALID=0; after release, the remaining 7 words follow in order.
- start pulsed again mid-packet, then after done -> the first is ignored; the second produces a complete second packet starting at 0x24379827.
- ap_rst_n asserted after beat 4 -> all outputs return to reset values asynchronously; a fresh start yields a full 9-word packet from address 0.
- With AXI_INFO_READER_ERR_EN, RRESP=2'b10 on word 3 -> err=1 stays set through done, data is still forwarded; the next start clears err.
